// File: rtl/date_diff_sequencer_if.sv
// Request/response bundle for date_diff_sequencer: one date pair in, one
// difference result out, each on its own valid/ready handshake.
interface date_diff_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] day1;
    logic [3:0] mon1;
    logic [4:0] day2;
    logic [3:0] mon2;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] day_diff;
    logic [3:0] mon_diff;
    logic       err;

    modport slave (
        input  in_valid, day1, mon1, day2, mon2, out_ready,
        output in_ready, out_valid, day_diff, mon_diff, err
    );

    modport master (
        output in_valid, day1, mon1, day2, mon2, out_ready,
        input  in_ready, out_valid, day_diff, mon_diff, err
    );
endinterface

// File: rtl/date_diff_sequencer.sv
// Multi-cycle day/month distance between two dates: validate, accumulate
// month lengths one month per cycle, then emit absolute differences.
module date_diff_sequencer #(
    parameter bit LEAP = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    date_diff_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ACC   = 3'd2,
        DIFF  = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] d1_q, d1_d, d2_q, d2_d;
    logic [3:0] m1_q, m1_d, m2_q, m2_d;
    logic [8:0] acc1_q, acc1_d, acc2_q, acc2_d;
    logic [3:0] m_q, m_d;
    logic [8:0] dd_q, dd_d;
    logic [3:0] md_q, md_d;
    logic       err_q, err_d;

    logic [3:0] mon_max;
    logic       ok1, ok2;
    logic [8:0] doy1, doy2;

    // Out-of-range months return 0, which also makes any day for them invalid.
    function automatic logic [4:0] mlen(input logic [3:0] m);
        logic [4:0] len;
        case (m)
            4'd2:                      len = LEAP ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   len = 5'd30;
            4'd1, 4'd3, 4'd5, 4'd7,
            4'd8, 4'd10, 4'd12:        len = 5'd31;
            default:                   len = 5'd0;
        endcase
        return len;
    endfunction

    always_comb begin
        mon_max = (m1_q > m2_q) ? m1_q : m2_q;
        ok1     = (m1_q != 4'd0) && (m1_q <= 4'd12) && (d1_q != 5'd0) && (d1_q <= mlen(m1_q));
        ok2     = (m2_q != 4'd0) && (m2_q <= 4'd12) && (d2_q != 5'd0) && (d2_q <= mlen(m2_q));
        doy1    = acc1_q + {4'd0, d1_q};
        doy2    = acc2_q + {4'd0, d2_q};
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.in_valid) state_d = CHECK;
            CHECK: begin
                if (!(ok1 && ok2))           state_d = DONE;
                else if (mon_max == 4'd1)    state_d = DIFF;
                else                         state_d = ACC;
            end
            ACC:   if (m_q == mon_max - 4'd1) state_d = DIFF;
            DIFF:  state_d = DONE;
            DONE:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.day_diff  = dd_q;
        bus.mon_diff  = md_q;
        bus.err       = err_q;
    end

    always_comb begin
        d1_d   = d1_q;
        d2_d   = d2_q;
        m1_d   = m1_q;
        m2_d   = m2_q;
        acc1_d = acc1_q;
        acc2_d = acc2_q;
        m_d    = m_q;
        dd_d   = dd_q;
        md_d   = md_q;
        err_d  = err_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                d1_d   = bus.day1;
                m1_d   = bus.mon1;
                d2_d   = bus.day2;
                m2_d   = bus.mon2;
                acc1_d = 9'd0;
                acc2_d = 9'd0;
                m_d    = 4'd1;
            end
            CHECK: if (!(ok1 && ok2)) begin
                err_d = 1'b1;
                dd_d  = 9'd0;
                md_d  = 4'd0;
            end
            ACC: begin
                if (m_q < m1_q) acc1_d = acc1_q + {4'd0, mlen(m_q)};
                if (m_q < m2_q) acc2_d = acc2_q + {4'd0, mlen(m_q)};
                m_d = m_q + 4'd1;
            end
            DIFF: begin
                dd_d  = (doy1 > doy2) ? (doy1 - doy2) : (doy2 - doy1);
                md_d  = (m1_q > m2_q) ? (m1_q - m2_q) : (m2_q - m1_q);
                err_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d1_q   <= '0;
            d2_q   <= '0;
            m1_q   <= '0;
            m2_q   <= '0;
            acc1_q <= '0;
            acc2_q <= '0;
            m_q    <= '0;
            dd_q   <= '0;
            md_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            d1_q   <= d1_d;
            d2_q   <= d2_d;
            m1_q   <= m1_d;
            m2_q   <= m2_d;
            acc1_q <= acc1_d;
            acc2_q <= acc2_d;
            m_q    <= m_d;
            dd_q   <= dd_d;
            md_q   <= md_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_date_diff_sequencer.sv
// Randomized bench for date_diff_sequencer against a calendar reference model,
// with one instance per LEAP setting.
module tb_date_diff_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    date_diff_sequencer_if if0();
    date_diff_sequencer_if if1();

    date_diff_sequencer #(.LEAP(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    date_diff_sequencer #(.LEAP(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int mlen(input int m, input int leap);
        case (m)
            2:              return 28 + leap;
            4, 6, 9, 11:    return 30;
            1, 3, 5, 7, 8, 10, 12: return 31;
            default:        return 0;
        endcase
    endfunction

    function automatic int doy(input int d, input int m, input int leap);
        int s = d;
        for (int i = 1; i < m; i++) s += mlen(i, leap);
        return s;
    endfunction

    function automatic bit date_ok(input int d, input int m, input int leap);
        return (m >= 1) && (m <= 12) && (d >= 1) && (d <= mlen(m, leap));
    endfunction

    task automatic model(input int leap, input int d1, input int m1, input int d2, input int m2,
                         output int dd, output int md, output int e, output int lat);
        if (!(date_ok(d1, m1, leap) && date_ok(d2, m2, leap))) begin
            dd = 0; md = 0; e = 1; lat = 1;
        end else begin
            dd  = doy(d1, m1, leap) - doy(d2, m2, leap);
            if (dd < 0) dd = -dd;
            md  = (m1 > m2) ? m1 - m2 : m2 - m1;
            e   = 0;
            lat = ((m1 > m2) ? m1 : m2) + 1;
        end
    endtask

    task automatic drive_in(input int w, input int v, input int d1, input int m1, input int d2, input int m2);
        if (w == 0) begin
            if0.in_valid = 1'(v); if0.day1 = 5'(d1); if0.mon1 = 4'(m1);
            if0.day2 = 5'(d2); if0.mon2 = 4'(m2);
        end else begin
            if1.in_valid = 1'(v); if1.day1 = 5'(d1); if1.mon1 = 4'(m1);
            if1.day2 = 5'(d2); if1.mon2 = 4'(m2);
        end
    endtask

    task automatic set_ordy(input int w, input int r);
        if (w == 0) if0.out_ready = 1'(r);
        else        if1.out_ready = 1'(r);
    endtask

    task automatic sample(input int w, output int ov, output int ir, output int dd, output int md, output int e);
        if (w == 0) begin
            ov = int'(if0.out_valid); ir = int'(if0.in_ready); dd = int'(if0.day_diff);
            md = int'(if0.mon_diff);  e  = int'(if0.err);
        end else begin
            ov = int'(if1.out_valid); ir = int'(if1.in_ready); dd = int'(if1.day_diff);
            md = int'(if1.mon_diff);  e  = int'(if1.err);
        end
    endtask

    // One full transaction: accept, measure latency, hold in DONE for `hold` cycles
    // while scribbling on the inputs, then release and confirm the return to IDLE.
    task automatic do_req(input int w, input int d1, input int m1, input int d2, input int m2,
                          input int hold, input string tag);
        int ov, ir, dd, md, e, lat;
        int xdd, xmd, xe, xlat;
        model(w, d1, m1, d2, m2, xdd, xmd, xe, xlat);
        @(negedge clk);
        sample(w, ov, ir, dd, md, e);
        chk({tag, ":in_ready_idle"}, ir, 1);
        set_ordy(w, 0);
        drive_in(w, 1, d1, m1, d2, m2);
        @(posedge clk);
        @(negedge clk);
        drive_in(w, 0, $urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 15));
        lat = 0;
        sample(w, ov, ir, dd, md, e);
        while (ov == 0 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            sample(w, ov, ir, dd, md, e);
        end
        chk({tag, ":latency"}, lat, xlat);
        chk({tag, ":out_valid"}, ov, 1);
        chk({tag, ":day_diff"}, dd, xdd);
        chk({tag, ":mon_diff"}, md, xmd);
        chk({tag, ":err"}, e, xe);
        chk({tag, ":in_ready_done"}, ir, 0);
        for (int i = 0; i < hold; i++) begin
            drive_in(w, int'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 15),
                     $urandom_range(0, 31), $urandom_range(0, 15));
            @(posedge clk);
            @(negedge clk);
            sample(w, ov, ir, dd, md, e);
            chk({tag, ":hold_valid"}, ov, 1);
            chk({tag, ":hold_ready"}, ir, 0);
            chk({tag, ":hold_result"}, dd * 64 + md * 2 + e, xdd * 64 + xmd * 2 + xe);
        end
        drive_in(w, 0, 0, 0, 0, 0);
        set_ordy(w, 1);
        @(posedge clk);
        @(negedge clk);
        set_ordy(w, 0);
        sample(w, ov, ir, dd, md, e);
        chk({tag, ":released_valid"}, ov, 0);
        chk({tag, ":released_ready"}, ir, 1);
    endtask

    initial begin
        int ov, ir, dd, md, e;
        drive_in(0, 0, 0, 0, 0, 0);
        drive_in(1, 0, 0, 0, 0, 0);
        set_ordy(0, 0);
        set_ordy(1, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            sample(w, ov, ir, dd, md, e);
            chk("reset_out_valid", ov, 0);
            chk("reset_in_ready", ir, 1);
            chk("reset_result", dd + md + e, 0);
        end
        rst_n = 1'b1;

        do_req(0, 1, 1, 31, 12, 0, "full_year");
        do_req(0, 15, 3, 10, 2, 0, "short");
        do_req(0, 10, 2, 15, 3, 0, "short_swap");
        do_req(0, 30, 2, 1, 1, 0, "feb30");
        do_req(0, 1, 1, 1, 13, 0, "mon13");
        do_req(0, 0, 5, 1, 1, 0, "day0");
        do_req(1, 29, 2, 1, 3, 0, "leap_feb29");
        do_req(0, 31, 12, 1, 1, 0, "full_year_swap");
        do_req(0, 7, 7, 7, 7, 5, "backpressure");

        // Reset during ACC of a 12-month request must discard it silently.
        @(negedge clk);
        drive_in(0, 1, 3, 1, 20, 12);
        @(posedge clk);
        @(negedge clk);
        drive_in(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sample(0, ov, ir, dd, md, e);
        chk("midreset_out_valid", ov, 0);
        chk("midreset_in_ready", ir, 1);
        chk("midreset_result", dd + md + e, 0);
        repeat (15) @(posedge clk);
        @(negedge clk);
        sample(0, ov, ir, dd, md, e);
        chk("midreset_no_output", ov, 0);
        do_req(0, 5, 6, 5, 6, 0, "after_reset");

        for (int n = 0; n < 200; n++) begin
            int rd1, rm1, rd2, rm2;
            rd1 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 31);
            rm1 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 12);
            rd2 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 31);
            rm2 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 12);
            do_req(int'(n % 4 == 3), rd1, rm1, rd2, rm2, $urandom_range(0, 3), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
